// File: rtl/xilly_axil_regbank_if.sv
// AXI4-Lite slave bus bundle for the xilly_axil_regbank register bank.
// The slave modport is the register bank's view; the master modport drives it.
interface xilly_axil_regbank_if;
  logic [31:0] S_AXI_AWADDR;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [31:0] S_AXI_ARADDR;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );
endinterface

// File: rtl/xilly_axil_regbank.sv
// AXI4-Lite register bank: CTRL, STATUS, interrupt pending/mask and scratch words.
// Define XILLY_REGBANK_IRQ_EN to build the interrupt logic; otherwise it reads 0.
module xilly_axil_regbank #(
  parameter int NREGS  = 16,
  parameter int ADDR_W = 12
) (
  input  logic                 xillybus_bus_clk,
  input  logic                 xillybus_bus_rst_n,
  xilly_axil_regbank_if.slave  s_axi,
  output logic [31:0]          ctrl_out,
  input  logic [31:0]          status_in,
  input  logic [7:0]           irq_src,
  output logic                 host_interrupt
);

  localparam int          IDX_W   = ADDR_W - 2;
  localparam int          RIDX_W  = $clog2(NREGS);
  localparam logic [31:0] NREGS_U = NREGS;

  typedef logic [IDX_W-1:0] idx_t;
  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_e;

  localparam idx_t IDX_STATUS   = idx_t'(1);
  localparam idx_t IDX_IRQ_PEND = idx_t'(2);
  localparam idx_t IDX_IRQ_MASK = idx_t'(3);

  logic        run_q;
  logic        aw_full_q, w_full_q;
  idx_t        aw_idx_q;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;
  logic        bvalid_q, rvalid_q;
  resp_e       bresp_q, rresp_q;
  logic [31:0] rdata_q;
  logic [31:0] regs_q [NREGS];

  logic        aw_ready, w_ready, ar_ready;
  logic        aw_hs, w_hs, ar_hs, commit, wr_err, wr_en;
  idx_t        ar_idx;
  logic [31:0] rd_word;
  logic        rd_err;
  logic [7:0]  irq_pend_rd, irq_mask_rd;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  // run_q keeps every ready low until the first edge after reset release.
  assign aw_ready = run_q & ~aw_full_q & ~bvalid_q;
  assign w_ready  = run_q & ~w_full_q  & ~bvalid_q;
  assign ar_ready = run_q & ~rvalid_q;

  assign aw_hs  = s_axi.S_AXI_AWVALID & aw_ready;
  assign w_hs   = s_axi.S_AXI_WVALID  & w_ready;
  assign ar_hs  = s_axi.S_AXI_ARVALID & ar_ready;
  assign commit = aw_full_q & w_full_q;
  assign wr_err = (32'(aw_idx_q) >= NREGS_U);
  assign wr_en  = commit & ~wr_err;
  assign ar_idx = s_axi.S_AXI_ARADDR[ADDR_W-1:2];

  assign s_axi.S_AXI_AWREADY = aw_ready;
  assign s_axi.S_AXI_WREADY  = w_ready;
  assign s_axi.S_AXI_ARREADY = ar_ready;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign ctrl_out            = regs_q[0];

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    rd_word = '0;
    rd_err  = 1'b0;
    if (32'(ar_idx) >= NREGS_U)      rd_err  = 1'b1;
    else if (ar_idx == IDX_STATUS)   rd_word = status_in;
    else if (ar_idx == IDX_IRQ_PEND) rd_word = {24'h0, irq_pend_rd};
    else if (ar_idx == IDX_IRQ_MASK) rd_word = {24'h0, irq_mask_rd};
    else                             rd_word = regs_q[ar_idx[RIDX_W-1:0]];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values; this is also what makes a same-edge read return the old contents.
  always_ff @(posedge xillybus_bus_clk or negedge xillybus_bus_rst_n) begin
    if (!xillybus_bus_rst_n) begin
      run_q     <= 1'b0;
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      aw_idx_q  <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      run_q <= 1'b1;
      if (aw_hs) begin
        aw_full_q <= 1'b1;
        aw_idx_q  <= s_axi.S_AXI_AWADDR[ADDR_W-1:2];
      end
      if (w_hs) begin
        w_full_q <= 1'b1;
        w_data_q <= s_axi.S_AXI_WDATA;
        w_strb_q <= s_axi.S_AXI_WSTRB;
      end
      if (commit) begin
        aw_full_q <= 1'b0;
        w_full_q  <= 1'b0;
        bvalid_q  <= 1'b1;
        bresp_q   <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end else if (bvalid_q && s_axi.S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_word;
        rresp_q  <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end else if (rvalid_q && s_axi.S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // NOTE: this register file is built from flops, so an asynchronous reset of the whole array is legal; a RAM-inferred array could not be reset this way.
  always_ff @(posedge xillybus_bus_clk or negedge xillybus_bus_rst_n) begin
    if (!xillybus_bus_rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        // Words 1..3 are STATUS and the interrupt pair; they never live here.
        if (wr_en && aw_idx_q == idx_t'(i) && (i == 0 || i >= 4))
          regs_q[i] <= merge_bytes(regs_q[i], w_data_q, w_strb_q);
      end
    end
  end

`ifdef XILLY_REGBANK_IRQ_EN
  logic [7:0] irq_pend_q, irq_mask_q, irq_prev_q, irq_rise, irq_clr;
  logic       host_int_q, mask_wr;

  assign irq_rise = irq_src & ~irq_prev_q;
  assign irq_clr  = (wr_en && aw_idx_q == IDX_IRQ_PEND && w_strb_q[0]) ? w_data_q[7:0] : 8'h00;
  assign mask_wr  = wr_en && aw_idx_q == IDX_IRQ_MASK && w_strb_q[0];

  always_ff @(posedge xillybus_bus_clk or negedge xillybus_bus_rst_n) begin
    if (!xillybus_bus_rst_n) begin
      irq_prev_q <= '0;
      irq_pend_q <= '0;
      irq_mask_q <= '0;
      host_int_q <= 1'b0;
    end else begin
      irq_prev_q <= irq_src;
      // A new edge wins over a same-cycle clear.
      irq_pend_q <= (irq_pend_q & ~irq_clr) | irq_rise;
      if (mask_wr) irq_mask_q <= w_data_q[7:0];
      host_int_q <= |(irq_pend_q & irq_mask_q);
    end
  end

  assign irq_pend_rd    = irq_pend_q;
  assign irq_mask_rd    = irq_mask_q;
  assign host_interrupt = host_int_q;
`else
  logic unused_irq;
  assign unused_irq     = ^irq_src;
  assign irq_pend_rd    = 8'h00;
  assign irq_mask_rd    = 8'h00;
  assign host_interrupt = 1'b0;
`endif

  // Address bits outside [ADDR_W-1:2] are deliberately ignored.
  logic unused_addr;
  assign unused_addr = ^{s_axi.S_AXI_AWADDR, s_axi.S_AXI_ARADDR};

endmodule

// File: tb/tb_xilly_axil_regbank.sv
// Self-checking bench for xilly_axil_regbank: directed vector table, hand-written
// corner sequences and a randomized phase checked against a word-level model.
`timescale 1ns/1ps
module tb_xilly_axil_regbank;
  localparam int NREGS  = 16;
  localparam int ADDR_W = 12;
`ifdef XILLY_REGBANK_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ctrl_out;
  logic [31:0] status_in;
  logic [7:0]  irq_src;
  logic        host_interrupt;

  xilly_axil_regbank_if bus ();

  xilly_axil_regbank #(.NREGS(NREGS), .ADDR_W(ADDR_W)) dut (
    .xillybus_bus_clk  (clk),
    .xillybus_bus_rst_n(rst_n),
    .s_axi             (bus),
    .ctrl_out          (ctrl_out),
    .status_in         (status_in),
    .irq_src           (irq_src),
    .host_interrupt    (host_interrupt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: plain word array ----------------
  logic [31:0] m_regs [NREGS];
  logic [7:0]  m_pend, m_mask;

  function automatic int widx(input logic [31:0] a);
    return int'((a & ((32'd1 << ADDR_W) - 32'd1)) >> 2);
  endfunction

  function automatic logic [1:0] m_resp(input logic [31:0] a);
    return (widx(a) >= NREGS) ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [31:0] m_data(input logic [31:0] a);
    int i;
    i = widx(a);
    if (i >= NREGS) return 32'h0;
    case (i)
      1:       return status_in;
      2:       return IRQ_EN ? {24'h0, m_pend} : 32'h0;
      3:       return IRQ_EN ? {24'h0, m_mask} : 32'h0;
      default: return m_regs[i];
    endcase
  endfunction

  function automatic void m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int i;
    logic [31:0] v;
    i = widx(a);
    if (i >= NREGS || i == 1) return;
    if (i == 2) begin
      if (IRQ_EN && s[0]) m_pend = m_pend & ~d[7:0];
      return;
    end
    if (i == 3) begin
      if (IRQ_EN && s[0]) m_mask = d[7:0];
      return;
    end
    v = m_regs[i];
    for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
    m_regs[i] = v;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < NREGS; i++) m_regs[i] = 32'h0;
    m_pend = 8'h0;
    m_mask = 8'h0;
  endfunction

  // ---------------- bus tasks (start and end just after a negedge) ----------------
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input bit ack,
                           output logic [1:0] resp);
    int c;
    bit aw_done, w_done, aw_hs, w_hs;
    c = 0; aw_done = 0; w_done = 0;
    while (!(aw_done && w_done) && c < 100) begin
      if (!aw_done && c >= aw_dly) begin bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_AWADDR = a; end
      if (!w_done && c >= w_dly) begin
        bus.S_AXI_WVALID = 1'b1; bus.S_AXI_WDATA = d; bus.S_AXI_WSTRB = s;
      end
      aw_hs = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
      w_hs  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
      @(negedge clk);
      c++;
      if (aw_hs) begin aw_done = 1; bus.S_AXI_AWVALID = 1'b0; end
      if (w_hs)  begin w_done = 1;  bus.S_AXI_WVALID = 1'b0; end
    end
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    check("write_accept", {30'h0, aw_done, w_done}, 32'd3);
    c = 0;
    while (!bus.S_AXI_BVALID && c < 100) begin @(negedge clk); c++; end
    check("bvalid_seen", {31'h0, bus.S_AXI_BVALID}, 32'd1);
    resp = bus.S_AXI_BRESP;
    if (ack) begin
      bus.S_AXI_BREADY = 1'b1;
      @(negedge clk);
      bus.S_AXI_BREADY = 1'b0;
    end
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    int c;
    c = 0;
    bus.S_AXI_ARVALID = 1'b1;
    bus.S_AXI_ARADDR  = a;
    while (!bus.S_AXI_ARREADY && c < 100) begin @(negedge clk); c++; end
    @(negedge clk);
    bus.S_AXI_ARVALID = 1'b0;
    c = 0;
    while (!bus.S_AXI_RVALID && c < 100) begin @(negedge clk); c++; end
    check("rvalid_seen", {31'h0, bus.S_AXI_RVALID}, 32'd1);
    d    = bus.S_AXI_RDATA;
    resp = bus.S_AXI_RRESP;
    bus.S_AXI_RREADY = 1'b1;
    @(negedge clk);
    bus.S_AXI_RREADY = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_awready"}, {31'h0, bus.S_AXI_AWREADY}, 32'd0);
    check({tag, "_wready"},  {31'h0, bus.S_AXI_WREADY},  32'd0);
    check({tag, "_arready"}, {31'h0, bus.S_AXI_ARREADY}, 32'd0);
    check({tag, "_bvalid"},  {31'h0, bus.S_AXI_BVALID},  32'd0);
    check({tag, "_rvalid"},  {31'h0, bus.S_AXI_RVALID},  32'd0);
    check({tag, "_bresp"},   {30'h0, bus.S_AXI_BRESP},   32'd0);
    check({tag, "_rresp"},   {30'h0, bus.S_AXI_RRESP},   32'd0);
    check({tag, "_rdata"},   bus.S_AXI_RDATA,            32'd0);
    check({tag, "_ctrl"},    ctrl_out,                   32'd0);
    check({tag, "_irq"},     {31'h0, host_interrupt},    32'd0);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          aw_dly;
    int          w_dly;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs[$];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] rd;
    logic [1:0]  rs;
    logic [31:0] a, d;
    logic [3:0]  s;
    int          idx, c;

    bus.S_AXI_AWVALID = 0; bus.S_AXI_AWADDR = 0;
    bus.S_AXI_WVALID = 0;  bus.S_AXI_WDATA = 0; bus.S_AXI_WSTRB = 0;
    bus.S_AXI_BREADY = 0;
    bus.S_AXI_ARVALID = 0; bus.S_AXI_ARADDR = 0;
    bus.S_AXI_RREADY = 0;
    status_in = 32'hA5A5_A5A5;
    irq_src   = 8'h00;
    m_reset();

    //          wr  addr           data           strb aw w  exp_data                  exp_resp
    vecs.push_back('{1, 32'h010,   32'hDEADBEEF, 4'hF, 0, 2, 32'h0,                    2'b00});
    vecs.push_back('{0, 32'h010,   32'h0,        4'h0, 0, 0, 32'hDEADBEEF,             2'b00});
    vecs.push_back('{1, 32'h000,   32'h12345678, 4'h5, 2, 0, 32'h0,                    2'b00});
    vecs.push_back('{0, 32'h000,   32'h0,        4'h0, 0, 0, 32'h00340078,             2'b00});
    vecs.push_back('{0, 32'h004,   32'h0,        4'h0, 0, 0, 32'hA5A5A5A5,             2'b00});
    vecs.push_back('{0, 32'h040,   32'h0,        4'h0, 0, 0, 32'h0,                    2'b10});
    vecs.push_back('{1, 32'h040,   32'h11111111, 4'hF, 0, 0, 32'h0,                    2'b10});
    vecs.push_back('{1, 32'h004,   32'hFFFFFFFF, 4'hF, 1, 0, 32'h0,                    2'b00});
    vecs.push_back('{0, 32'h004,   32'h0,        4'h0, 0, 0, 32'hA5A5A5A5,             2'b00});
    vecs.push_back('{0, 32'h013,   32'h0,        4'h0, 0, 0, 32'hDEADBEEF,             2'b00});
    vecs.push_back('{0, 32'h1010,  32'h0,        4'h0, 0, 0, 32'hDEADBEEF,             2'b00});
    vecs.push_back('{1, 32'h03C,   32'hCAFEF00D, 4'hC, 1, 1, 32'h0,                    2'b00});
    vecs.push_back('{0, 32'h03C,   32'h0,        4'h0, 0, 0, 32'hCAFE0000,             2'b00});
    vecs.push_back('{1, 32'h03F,   32'h000000AA, 4'h1, 0, 3, 32'h0,                    2'b00});
    vecs.push_back('{0, 32'h03C,   32'h0,        4'h0, 0, 0, 32'hCAFE00AA,             2'b00});
    vecs.push_back('{1, 32'h00C,   32'hFFFFFF03, 4'hF, 0, 0, 32'h0,                    2'b00});
    vecs.push_back('{0, 32'h00C,   32'h0,        4'h0, 0, 0, IRQ_EN ? 32'h3 : 32'h0,   2'b00});
    vecs.push_back('{0, 32'h008,   32'h0,        4'h0, 0, 0, 32'h0,                    2'b00});
    vecs.push_back('{0, 32'h0FC,   32'h0,        4'h0, 0, 0, 32'h0,                    2'b10});

    // Reset state, then readies rise one cycle after release.
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    check("awready_at_release", {31'h0, bus.S_AXI_AWREADY}, 32'd0);
    @(negedge clk);
    check("awready_after", {31'h0, bus.S_AXI_AWREADY}, 32'd1);
    check("wready_after",  {31'h0, bus.S_AXI_WREADY},  32'd1);
    check("arready_after", {31'h0, bus.S_AXI_ARREADY}, 32'd1);

    foreach (vecs[k]) begin
      if (vecs[k].wr) begin
        axi_write(vecs[k].addr, vecs[k].data, vecs[k].strb, vecs[k].aw_dly, vecs[k].w_dly, 1'b1, rs);
        check($sformatf("vec%0d_bresp", k), {30'h0, rs}, {30'h0, vecs[k].exp_resp});
        m_write(vecs[k].addr, vecs[k].data, vecs[k].strb);
      end else begin
        axi_read(vecs[k].addr, rd, rs);
        check($sformatf("vec%0d_rdata", k), rd, vecs[k].exp_data);
        check($sformatf("vec%0d_rresp", k), {30'h0, rs}, {30'h0, vecs[k].exp_resp});
      end
    end
    check("ctrl_out_vec", ctrl_out, 32'h00340078);

    // Response held while BREADY is low; no new address accepted meanwhile.
    axi_write(32'h014, 32'h0BADF00D, 4'hF, 2, 0, 1'b0, rs);
    repeat (5) begin
      @(negedge clk);
      check("bhold_bvalid",  {31'h0, bus.S_AXI_BVALID},  32'd1);
      check("bhold_bresp",   {30'h0, bus.S_AXI_BRESP},   32'd0);
      check("bhold_awready", {31'h0, bus.S_AXI_AWREADY}, 32'd0);
    end
    bus.S_AXI_BREADY = 1'b1;
    @(negedge clk);
    bus.S_AXI_BREADY = 1'b0;
    check("bhold_released", {31'h0, bus.S_AXI_BVALID}, 32'd0);
    m_write(32'h014, 32'h0BADF00D, 4'hF);

    // Read handshake on the commit edge of a write to the same word sees the old value.
    axi_write(32'h018, 32'h11111111, 4'hF, 0, 0, 1'b1, rs);
    m_write(32'h018, 32'h11111111, 4'hF);
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_AWADDR = 32'h018;
    bus.S_AXI_WVALID = 1'b1;  bus.S_AXI_WDATA = 32'h22222222; bus.S_AXI_WSTRB = 4'hF;
    @(negedge clk);
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_ARVALID = 1'b1; bus.S_AXI_ARADDR = 32'h018;
    check("race_arready", {31'h0, bus.S_AXI_ARREADY}, 32'd1);
    @(negedge clk);
    bus.S_AXI_ARVALID = 1'b0;
    check("race_rvalid", {31'h0, bus.S_AXI_RVALID}, 32'd1);
    check("race_rdata",  bus.S_AXI_RDATA, 32'h11111111);
    check("race_bvalid", {31'h0, bus.S_AXI_BVALID}, 32'd1);
    bus.S_AXI_BREADY = 1'b1; bus.S_AXI_RREADY = 1'b1;
    @(negedge clk);
    bus.S_AXI_BREADY = 1'b0; bus.S_AXI_RREADY = 1'b0;
    m_write(32'h018, 32'h22222222, 4'hF);
    axi_read(32'h018, rd, rs);
    check("race_after", rd, 32'h22222222);

`ifdef XILLY_REGBANK_IRQ_EN
    axi_write(32'h00C, 32'h1, 4'hF, 0, 0, 1'b1, rs);
    m_write(32'h00C, 32'h1, 4'hF);
    irq_src = 8'h01;
    @(negedge clk);
    irq_src = 8'h00;
    m_pend = m_pend | 8'h01;
    check("irq_not_yet", {31'h0, host_interrupt}, 32'd0);
    @(negedge clk);
    check("irq_asserted", {31'h0, host_interrupt}, 32'd1);
    axi_read(32'h008, rd, rs);
    check("irq_pend", rd, 32'h1);
    // Clear and a new edge on the same cycle: pending stays set.
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_AWADDR = 32'h008;
    bus.S_AXI_WVALID = 1'b1;  bus.S_AXI_WDATA = 32'h1; bus.S_AXI_WSTRB = 4'hF;
    @(negedge clk);
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    irq_src = 8'h01;
    @(negedge clk);
    irq_src = 8'h00;
    check("irq_race_bvalid", {31'h0, bus.S_AXI_BVALID}, 32'd1);
    bus.S_AXI_BREADY = 1'b1;
    @(negedge clk);
    bus.S_AXI_BREADY = 1'b0;
    axi_read(32'h008, rd, rs);
    check("irq_race_pend", rd, 32'h1);
    check("irq_race_int", {31'h0, host_interrupt}, 32'd1);
    axi_write(32'h008, 32'h1, 4'hF, 0, 0, 1'b0, rs);
    m_write(32'h008, 32'h1, 4'hF);
    check("irq_clear_same", {31'h0, host_interrupt}, 32'd1);
    @(negedge clk);
    check("irq_clear_next", {31'h0, host_interrupt}, 32'd0);
    bus.S_AXI_BREADY = 1'b1;
    @(negedge clk);
    bus.S_AXI_BREADY = 1'b0;
    axi_read(32'h008, rd, rs);
    check("irq_pend_cleared", rd, 32'h0);
`else
    axi_write(32'h00C, 32'hFF, 4'hF, 0, 0, 1'b1, rs);
    check("irqdis_bresp", {30'h0, rs}, 32'd0);
    irq_src = 8'hFF;
    repeat (2) @(negedge clk);
    irq_src = 8'h00;
    repeat (3) begin
      @(negedge clk);
      check("irqdis_int", {31'h0, host_interrupt}, 32'd0);
    end
    axi_read(32'h008, rd, rs);
    check("irqdis_pend", rd, 32'h0);
`endif

    // Reset with an address latched and no data: transaction is abandoned.
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_AWADDR = 32'h01C;
    @(negedge clk);
    bus.S_AXI_AWVALID = 1'b0;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.S_AXI_WVALID = 1'b1; bus.S_AXI_WDATA = 32'h00000077; bus.S_AXI_WSTRB = 4'hF;
    c = 0;
    while (!bus.S_AXI_WREADY && c < 100) begin @(negedge clk); c++; end
    @(negedge clk);
    bus.S_AXI_WVALID = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("midreset_no_b", {31'h0, bus.S_AXI_BVALID}, 32'd0);
    end
    check("midreset_awready", {31'h0, bus.S_AXI_AWREADY}, 32'd1);
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_AWADDR = 32'h01C;
    @(negedge clk);
    bus.S_AXI_AWVALID = 1'b0;
    @(negedge clk);
    check("midreset_complete", {31'h0, bus.S_AXI_BVALID}, 32'd1);
    bus.S_AXI_BREADY = 1'b1;
    @(negedge clk);
    bus.S_AXI_BREADY = 1'b0;
    m_write(32'h01C, 32'h00000077, 4'hF);
    axi_read(32'h01C, rd, rs);
    check("midreset_word", rd, m_data(32'h01C));
    axi_read(32'h010, rd, rs);
    check("midreset_cleared", rd, m_data(32'h010));

    // Randomized traffic against the model.
    for (int k = 0; k < 300; k++) begin
      idx = $urandom_range(0, NREGS + 3);
      a = ($urandom & ~((32'd1 << ADDR_W) - 32'd1)) | (32'(idx) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), 1'b1, rs);
        check($sformatf("rnd%0d_bresp", k), {30'h0, rs}, {30'h0, m_resp(a)});
        m_write(a, d, s);
      end else begin
        status_in = $urandom;
        axi_read(a, rd, rs);
        check($sformatf("rnd%0d_rdata", k), rd, m_data(a));
        check($sformatf("rnd%0d_rresp", k), {30'h0, rs}, {30'h0, m_resp(a)});
      end
    end
    check("ctrl_out_final", ctrl_out, m_regs[0]);
    check("host_int_final", {31'h0, host_interrupt}, {31'h0, |(m_pend & m_mask) & IRQ_EN});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
